ip_ram_arbiter: RTL and testbench
=================================

# ip_ram_arbiter

Two-port arbiter between the megarom RAM request interface and a second requester (ROM image loader / host), sharing one downstream memory controller port. Each upstream port uses the megarom's rd/wr/busy/rdata_en protocol and gets one-entry request buffering. A state machine issues one transaction at a time downstream and routes the read data back to its owner.

## Interface
- ADDR_W, 22, address width on all ports.
- clk  in  1  system clock, all logic on rising edge.
- n_reset  in  1  reset; asynchronous, active-low.
- a_rd / a_wr  in  1  port A (megarom) read / write request, one-cycle pulse.
- a_busy  out  1  port A cannot accept a new request.
- a_address  in  ADDR_W  port A address, sampled with a_rd/a_wr.
- a_wdata  in  8  port A write data.
- a_rdata  out  8  port A read data, valid with a_rdata_en.
- a_rdata_en  out  1  port A read-data strobe, one-cycle pulse.
- b_rd, b_wr, b_busy, b_address, b_wdata, b_rdata, b_rdata_en: port B (loader), identical to port A.
- m_rd / m_wr  out  1  downstream read / write request, one-cycle registered pulse.
- m_busy  in  1  downstream cannot accept a request.
- m_address  out  ADDR_W  downstream address.
- m_wdata  out  8  downstream write data.
- m_rdata  in  8  downstream read data.
- m_rdata_en  in  1  downstream read-data strobe.

## Operation
- Per port, one pending slot: kind (rd/wr), address, wdata, valid flag.
- Request accepted when x_rd|x_wr = 1 and x_busy = 0: slot loads and sets valid.
- x_busy = slot valid OR (state = WAIT_RD and owner = x).
- Request while x_busy = 1: dropped, slot unchanged.
- x_rd and x_wr both high: treated as read; the write is dropped.
- States: IDLE, WAIT_RD.
- IDLE: if any slot is valid and m_busy = 0, grant one port. Drive m_rd or m_wr for one cycle with the slot's address/wdata, clear the slot valid, and record the owner.
  - Read grant: go to WAIT_RD.
  - Write grant: stay in IDLE.
- IDLE with m_busy = 1: no grant; slots hold.
- WAIT_RD: on m_rdata_en = 1, register m_rdata into the owner's x_rdata, pulse the owner's x_rdata_en, and return to IDLE. No new grant is made in this cycle.
- Non-owner x_rdata stays 0. x_rdata returns to 0 when x_rdata_en drops.
- m_rdata_en in IDLE: ignored.
- Both slots valid: port A wins (default priority).

## Timing
- Reset values: all outputs 0, state IDLE, slots invalid, owner = A, round-robin pointer = A.
- Request sampled at edge N. m_rd/m_wr high during cycle N+1 if the arbiter is idle, m_busy = 0 and the port wins.
- m_rdata_en sampled at edge K: x_rdata/x_rdata_en high during cycle K+1.
- Minimum read latency, a_rd to a_rdata_en: 2 cycles plus downstream latency.
- Back-to-back writes from one port: new write accepted one cycle after m_wr issues, because busy clears once the slot is consumed.
- m_rd/m_wr: always exactly one cycle wide; never both high.
- Reset asserted mid-transaction: everything clears immediately and asynchronously. An in-flight downstream read is abandoned; a later m_rdata_en is ignored in IDLE.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: round-robin between A and B.
  - When both slots are valid, the port not granted last wins.
  - The pointer updates on every grant.
- Not defined: fixed priority, port A always first. The pointer register is not built.

## Structure
- Package ip_ram_arbiter_pkg:
  - state enum (ST_IDLE, ST_WAIT_RD);
  - port-select enum (PORT_A, PORT_B);
  - request-slot struct (rd, address, wdata, valid).
- Sub-module ip_ram_req_slot (one per port): accept logic, slot registers, busy generation. Instantiated twice.

## Test plan
- Reset: after n_reset release, all outputs 0, a_busy = b_busy = 0.
- Single read: a_rd, address 22'h02_4000, downstream returns 8'hA5 after 3 cycles -> m_address = 22'h02_4000, a_rdata = 8'hA5 with a_rdata_en for 1 cycle, b_rdata_en stays 0.
- Collision: a_wr to 22'h000100 with 8'h11 and b_rd to 22'h3FFFFF in the same cycle.
  - Fixed priority: m_wr(000100, 11) issues first, then m_rd(3FFFFF).
  - With RAM_ARB_ROUND_ROBIN_EN, after a prior A grant: B issues first.
- Backpressure: m_busy held high 5 cycles with a_rd pending -> no m_rd, a_busy = 1 throughout. m_rd issues the cycle after m_busy falls.
- Dropped request: second a_rd (22'h000200) while the first is pending -> exactly one m_rd, for the first address only.
- Reset mid-read: n_reset pulsed in WAIT_RD, then m_rdata_en arrives -> no a_rdata_en/b_rdata_en, state IDLE, busy 0.

Source files
------------

// File: rtl/ip_ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, port select, request slot.
package ip_ram_arbiter_pkg;

  localparam int unsigned RAM_ADDR_W = 22;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_RD
  } state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_e;

  typedef struct packed {
    logic                  rd;
    logic [RAM_ADDR_W-1:0] address;
    logic [7:0]            wdata;
    logic                  valid;
  } req_slot_t;

endpackage

// File: rtl/ip_ram_req_slot.sv
// One-entry request buffer for a single upstream port, with busy generation.
module ip_ram_req_slot
  import ip_ram_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic [RAM_ADDR_W-1:0] address_i,
  input  logic [7:0]            wdata_i,
  input  logic                  consume_i,
  input  logic                  rd_owned_i,
  output req_slot_t             slot_o,
  output logic                  busy_o
);

  req_slot_t slot_q, slot_d;
  logic      accept;

  assign busy_o = slot_q.valid | rd_owned_i;
  assign accept = (rd_i | wr_i) & ~busy_o;
  assign slot_o = slot_q;

  // rd wins when both strobes are high; accept and consume are exclusive
  // because consume requires valid, which forces busy.
  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d.rd      = rd_i;
      slot_d.address = address_i;
      slot_d.wdata   = wdata_i;
      slot_d.valid   = 1'b1;
    end else if (consume_i) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) slot_q <= '0;
    else          slot_q <= slot_d;
  end

endmodule

// File: rtl/ip_ram_arbiter.sv
// Two-port arbiter (megarom RAM port A, loader port B) onto one memory port.
// Optional: RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed A-first.
module ip_ram_arbiter
  import ip_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              a_rd,
  input  logic              a_wr,
  output logic              a_busy,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  output logic              a_rdata_en,
  input  logic              b_rd,
  input  logic              b_wr,
  output logic              b_busy,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata,
  output logic              b_rdata_en,
  output logic              m_rd,
  output logic              m_wr,
  input  logic              m_busy,
  output logic [ADDR_W-1:0] m_address,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_rdata_en
);

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  req_slot_t         slot_a, slot_b, sel;
  logic              grant_a, grant_b, pick_b;
  logic              m_rd_q, m_rd_d, m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [7:0]        m_wdata_q, m_wdata_d;
  logic [7:0]        a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_rdata_en_q, a_rdata_en_d, b_rdata_en_q, b_rdata_en_d;

  ip_ram_req_slot u_slot_a (
    .clk        (clk),
    .n_reset    (n_reset),
    .rd_i       (a_rd),
    .wr_i       (a_wr),
    .address_i  (a_address),
    .wdata_i    (a_wdata),
    .consume_i  (grant_a),
    .rd_owned_i ((state_q == ST_WAIT_RD) && (owner_q == PORT_A)),
    .slot_o     (slot_a),
    .busy_o     (a_busy)
  );

  ip_ram_req_slot u_slot_b (
    .clk        (clk),
    .n_reset    (n_reset),
    .rd_i       (b_rd),
    .wr_i       (b_wr),
    .address_i  (b_address),
    .wdata_i    (b_wdata),
    .consume_i  (grant_b),
    .rd_owned_i ((state_q == ST_WAIT_RD) && (owner_q == PORT_B)),
    .slot_o     (slot_b),
    .busy_o     (b_busy)
  );

`ifdef RAM_ARB_ROUND_ROBIN_EN
  port_e last_q, last_d;
  // On a tie the port that was not granted last goes first.
  assign pick_b = slot_b.valid & (~slot_a.valid | (last_q == PORT_A));
`else
  assign pick_b = slot_b.valid & ~slot_a.valid;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    sel          = pick_b ? slot_b : slot_a;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    m_rd_d       = 1'b0;
    m_wr_d       = 1'b0;
    m_address_d  = m_address_q;
    m_wdata_d    = m_wdata_q;
    a_rdata_d    = '0;
    a_rdata_en_d = 1'b0;
    b_rdata_d    = '0;
    b_rdata_en_d = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((slot_a.valid | slot_b.valid) & ~m_busy) begin
          grant_a     = ~pick_b;
          grant_b     = pick_b;
          owner_d     = pick_b ? PORT_B : PORT_A;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d      = owner_d;
`endif
          m_rd_d      = sel.rd;
          m_wr_d      = ~sel.rd;
          m_address_d = sel.address;
          m_wdata_d   = sel.wdata;
          if (sel.rd) state_d = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (m_rdata_en) begin
          state_d = ST_IDLE;
          if (owner_q == PORT_B) begin
            b_rdata_d    = m_rdata;
            b_rdata_en_d = 1'b1;
          end else begin
            a_rdata_d    = m_rdata;
            a_rdata_en_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_A;
      m_rd_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_address_q  <= '0;
      m_wdata_q    <= '0;
      a_rdata_q    <= '0;
      a_rdata_en_q <= 1'b0;
      b_rdata_q    <= '0;
      b_rdata_en_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q       <= PORT_A;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      m_rd_q       <= m_rd_d;
      m_wr_q       <= m_wr_d;
      m_address_q  <= m_address_d;
      m_wdata_q    <= m_wdata_d;
      a_rdata_q    <= a_rdata_d;
      a_rdata_en_q <= a_rdata_en_d;
      b_rdata_q    <= b_rdata_d;
      b_rdata_en_q <= b_rdata_en_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign m_rd       = m_rd_q;
  assign m_wr       = m_wr_q;
  assign m_address  = m_address_q;
  assign m_wdata    = m_wdata_q;
  assign a_rdata    = a_rdata_q;
  assign a_rdata_en = a_rdata_en_q;
  assign b_rdata    = b_rdata_q;
  assign b_rdata_en = b_rdata_en_q;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Directed, table-driven bench for ip_ram_arbiter; RAM_ARB_ROUND_ROBIN_EN selects the tie-break rows.
module tb_ip_ram_arbiter;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        a_rd, a_wr, a_busy, a_rdata_en;
  logic [21:0] a_address;
  logic [7:0]  a_wdata, a_rdata;
  logic        b_rd, b_wr, b_busy, b_rdata_en;
  logic [21:0] b_address;
  logic [7:0]  b_wdata, b_rdata;
  logic        m_rd, m_wr, m_busy, m_rdata_en;
  logic [21:0] m_address;
  logic [7:0]  m_wdata, m_rdata;

  always #5 clk = ~clk;

  ip_ram_arbiter #(.ADDR_W(22)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .a_rd       (a_rd),
    .a_wr       (a_wr),
    .a_busy     (a_busy),
    .a_address  (a_address),
    .a_wdata    (a_wdata),
    .a_rdata    (a_rdata),
    .a_rdata_en (a_rdata_en),
    .b_rd       (b_rd),
    .b_wr       (b_wr),
    .b_busy     (b_busy),
    .b_address  (b_address),
    .b_wdata    (b_wdata),
    .b_rdata    (b_rdata),
    .b_rdata_en (b_rdata_en),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_busy     (m_busy),
    .m_address  (m_address),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_rdata_en (m_rdata_en)
  );

  typedef struct {
    logic        a_rd, a_wr;
    logic [21:0] a_addr;
    logic [7:0]  a_wd;
    logic        b_rd, b_wr;
    logic [21:0] b_addr;
    logic [7:0]  b_wd;
    logic        m_busy, m_ren;
    logic [7:0]  m_rdata;
    logic        e_mrd, e_mwr;
    logic [21:0] e_maddr;
    logic [7:0]  e_mwd;
    logic        e_abusy, e_bbusy, e_aen, e_ben;
    logic [7:0]  e_ard, e_brd;
  } vec_t;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam logic [21:0] HOLD_A = 22'h000100;
  localparam logic [7:0]  HOLD_W = 8'h11;
`else
  localparam logic [21:0] HOLD_A = 22'h3FFFFF;
  localparam logic [7:0]  HOLD_W = 8'h00;
`endif

  vec_t tbl[$];
  vec_t v;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic apply(input vec_t x);
    a_rd = x.a_rd; a_wr = x.a_wr; a_address = x.a_addr; a_wdata = x.a_wd;
    b_rd = x.b_rd; b_wr = x.b_wr; b_address = x.b_addr; b_wdata = x.b_wd;
    m_busy = x.m_busy; m_rdata_en = x.m_ren; m_rdata = x.m_rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input vec_t x);
    vectors++;
    if ({m_rd, m_wr, m_address, m_wdata, a_busy, b_busy, a_rdata_en, a_rdata, b_rdata_en, b_rdata} !==
        {x.e_mrd, x.e_mwr, x.e_maddr, x.e_mwd, x.e_abusy, x.e_bbusy, x.e_aen, x.e_ard, x.e_ben, x.e_brd}) begin
      miscompares++;
      $display("FAIL %s got mrd=%b mwr=%b maddr=%h mwd=%h abusy=%b bbusy=%b aen=%b ard=%h ben=%b brd=%h want mrd=%b mwr=%b maddr=%h mwd=%h abusy=%b bbusy=%b aen=%b ard=%h ben=%b brd=%h",
               nm, m_rd, m_wr, m_address, m_wdata, a_busy, b_busy, a_rdata_en, a_rdata, b_rdata_en, b_rdata,
               x.e_mrd, x.e_mwr, x.e_maddr, x.e_mwd, x.e_abusy, x.e_bbusy, x.e_aen, x.e_ard, x.e_ben, x.e_brd);
    end
  endtask

  initial begin
    // Single read, downstream answers on the third edge after m_rd.
    tbl.push_back('{default:'0});
    tbl.push_back('{a_rd:'1, a_addr:22'h024000, e_abusy:'1, default:'0});
    tbl.push_back('{e_mrd:'1, e_maddr:22'h024000, e_abusy:'1, default:'0});
    tbl.push_back('{e_maddr:22'h024000, e_abusy:'1, default:'0});
    tbl.push_back('{e_maddr:22'h024000, e_abusy:'1, default:'0});
    tbl.push_back('{m_ren:'1, m_rdata:8'hA5, e_maddr:22'h024000, e_aen:'1, e_ard:8'hA5, default:'0});
    tbl.push_back('{e_maddr:22'h024000, default:'0});
    // Collision: A write and B read in the same cycle.
    tbl.push_back('{a_wr:'1, a_addr:22'h000100, a_wd:8'h11, b_rd:'1, b_addr:22'h3FFFFF,
                    e_maddr:22'h024000, e_abusy:'1, e_bbusy:'1, default:'0});
`ifdef RAM_ARB_ROUND_ROBIN_EN
    tbl.push_back('{e_mrd:'1, e_maddr:22'h3FFFFF, e_abusy:'1, e_bbusy:'1, default:'0});
    tbl.push_back('{m_ren:'1, m_rdata:8'h5A, e_maddr:22'h3FFFFF, e_abusy:'1, e_ben:'1, e_brd:8'h5A, default:'0});
    tbl.push_back('{e_mwr:'1, e_maddr:22'h000100, e_mwd:8'h11, default:'0});
`else
    tbl.push_back('{e_mwr:'1, e_maddr:22'h000100, e_mwd:8'h11, e_bbusy:'1, default:'0});
    tbl.push_back('{e_mrd:'1, e_maddr:22'h3FFFFF, e_bbusy:'1, default:'0});
    tbl.push_back('{m_ren:'1, m_rdata:8'h5A, e_maddr:22'h3FFFFF, e_ben:'1, e_brd:8'h5A, default:'0});
`endif
    // Back-to-back writes from port A.
    tbl.push_back('{a_wr:'1, a_addr:22'h000010, a_wd:8'h22, e_maddr:HOLD_A, e_mwd:HOLD_W, e_abusy:'1, default:'0});
    tbl.push_back('{e_mwr:'1, e_maddr:22'h000010, e_mwd:8'h22, default:'0});
    tbl.push_back('{a_wr:'1, a_addr:22'h000011, a_wd:8'h33, e_maddr:22'h000010, e_mwd:8'h22, e_abusy:'1, default:'0});
    tbl.push_back('{e_mwr:'1, e_maddr:22'h000011, e_mwd:8'h33, default:'0});
    // Second read while the first is pending is dropped.
    tbl.push_back('{a_rd:'1, a_addr:22'h000300, e_maddr:22'h000011, e_mwd:8'h33, e_abusy:'1, default:'0});
    tbl.push_back('{a_rd:'1, a_addr:22'h000200, e_mrd:'1, e_maddr:22'h000300, e_abusy:'1, default:'0});
    tbl.push_back('{e_maddr:22'h000300, e_abusy:'1, default:'0});
    tbl.push_back('{m_ren:'1, m_rdata:8'h3C, e_maddr:22'h000300, e_aen:'1, e_ard:8'h3C, default:'0});
    tbl.push_back('{e_maddr:22'h000300, default:'0});
    // Stray read strobe in IDLE, then rd+wr together behaves as a read.
    tbl.push_back('{m_ren:'1, m_rdata:8'hFF, e_maddr:22'h000300, default:'0});
    tbl.push_back('{a_rd:'1, a_wr:'1, a_addr:22'h000400, a_wd:8'h77, e_maddr:22'h000300, e_abusy:'1, default:'0});
    tbl.push_back('{e_mrd:'1, e_maddr:22'h000400, e_mwd:8'h77, e_abusy:'1, default:'0});
    tbl.push_back('{m_ren:'1, m_rdata:8'h01, e_maddr:22'h000400, e_mwd:8'h77, e_aen:'1, e_ard:8'h01, default:'0});
    tbl.push_back('{e_maddr:22'h000400, e_mwd:8'h77, default:'0});

    n_reset = 1'b0;
    apply('{default:'0});
    repeat (3) tick();
    check("reset_held", '{default:'0});
    n_reset = 1'b1;
    tick();
    check("reset_released", '{default:'0});

    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      check($sformatf("vec%0d", i), tbl[i]);
    end

    // Backpressure: m_busy high for 5 cycles with a read pending.
    apply('{a_rd:'1, a_addr:22'h000500, m_busy:'1, default:'0});
    tick();
    v = '{e_maddr:22'h000400, e_mwd:8'h77, e_abusy:'1, default:'0};
    check("bp_accept", v);
    apply('{m_busy:'1, default:'0});
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), v);
    end
    apply('{default:'0});
    tick();
    check("bp_issue", '{e_mrd:'1, e_maddr:22'h000500, e_abusy:'1, default:'0});
    tick();
    check("bp_wait", '{e_maddr:22'h000500, e_abusy:'1, default:'0});
    apply('{m_ren:'1, m_rdata:8'h96, default:'0});
    tick();
    check("bp_rdata", '{e_maddr:22'h000500, e_aen:'1, e_ard:8'h96, default:'0});
    apply('{default:'0});
    tick();

    // Reset pulsed while waiting for read data; the late strobe must be ignored.
    apply('{a_rd:'1, a_addr:22'h000600, default:'0});
    tick();
    apply('{default:'0});
    tick();
    check("rst_pre", '{e_mrd:'1, e_maddr:22'h000600, e_abusy:'1, default:'0});
    #2 n_reset = 1'b0;
    #2 check("rst_async", '{default:'0});
    #1 n_reset = 1'b1;
    apply('{m_ren:'1, m_rdata:8'h44, default:'0});
    tick();
    check("rst_late_ren", '{default:'0});
    apply('{default:'0});
    tick();
    check("rst_idle", '{default:'0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against m_rd/m_wr ever overlapping.
  always @(negedge clk) begin
    if (n_reset && m_rd && m_wr) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_wr_overlap got m_rd=%b m_wr=%b want at most one high", m_rd, m_wr);
    end
  end

endmodule
